// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky error flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered (1 clk).
module fifo_param #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = 12,
    parameter  int AE_LEVEL = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] AF_TH = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_TH = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, cnt_q;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic             rd_ok, wr_ok;

    // Extra wrap bit distinguishes full from empty when the address bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_ok);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_ok);

    assign count        = cnt_q;
    assign almost_full  = (cnt_q >= AF_TH);
    assign almost_empty = (cnt_q <= AE_TH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            cnt_q  <= wr_ptr_nxt - rd_ptr_nxt;
            if (wr && !wr_ok) overflow  <= 1'b1;
            if (rd && empty)  underflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem[wr_ptr[AW-1:0]] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = mem[rd_ptr[AW-1:0]];
    assign rd_valid = ~empty;
`else
    logic [WIDTH-1:0] dout_q;
    logic             rvld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            rvld_q <= 1'b0;
        end else if (clr) begin
            rvld_q <= 1'b0;
        end else begin
            rvld_q <= rd_ok;
            if (rd_ok) dout_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign data_out = dout_q;
    assign rd_valid = rvld_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Randomised and directed bench for fifo_param against a queue-based occupancy/data model.
module tb_fifo_param;

    logic       clk, rst, clr, wr, rd;
    logic [7:0] data_in, data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;

    logic [7:0] q[$];
    bit         m_ovf, m_unf, m_rv;
    logic [7:0] m_do;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".count"}, 32'(count), 32'(q.size()));
        chk({ph, ".full"}, 32'(full), 32'(q.size() == 16));
        chk({ph, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({ph, ".afull"}, 32'(almost_full), 32'(q.size() >= 12));
        chk({ph, ".aempty"}, 32'(almost_empty), 32'(q.size() <= 2));
        chk({ph, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({ph, ".unf"}, 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk({ph, ".rvalid"}, 32'(rd_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({ph, ".dout"}, 32'(data_out), 32'(q[0]));
`else
        chk({ph, ".rvalid"}, 32'(rd_valid), 32'(m_rv));
        chk({ph, ".dout"}, 32'(data_out), 32'(m_do));
`endif
    endtask

    // One clock: drive, take the edge, advance the model, then compare.
    task automatic cycle(input string ph, input bit w, input logic [7:0] d, input bit r, input bit c = 0);
        bit rok, wok;
        wr = w; data_in = d; rd = r; clr = c;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rv = 0;
        end else begin
            rok = r && (q.size() != 0);
            wok = w && ((q.size() < 16) || rok);
            if (w && !wok) m_ovf = 1;
            if (r && q.size() == 0) m_unf = 1;
            if (rok) m_do = q.pop_front();
            m_rv = rok;
            if (wok) q.push_back(d);
        end
        #1;
        wr = 0; rd = 0; clr = 0;
        check_all(ph);
    endtask

    task automatic do_reset(input string ph);
        rst = 1'b0;
        #2;
        q.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0; m_do = 8'h00;
        check_all({ph, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all({ph, ".rel"});
    endtask

    initial begin
        rst = 1'b0; clr = 0; wr = 0; rd = 0; data_in = 0;
        m_do = 8'h00;
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Mid-run reset discards contents and sticky flags
        for (int i = 0; i < 5; i++) cycle("pre", 1, 8'(8'h50 + i), 0);
        cycle("pre_udf", 0, 8'h00, 0);
        do_reset("rst_mid");
        chk("rst_mid.count0", 32'(count), 32'd0);
        chk("rst_mid.dout0", 32'(data_out), 32'd0);

        // Fill to full, overflow, then drain in order
        for (int i = 0; i < 16; i++) begin
            cycle("fill", 1, 8'(i), 0);
            chk("fill.af_edge", 32'(almost_full), 32'(i + 1 >= 12));
        end
        chk("fill.full16", 32'(full), 32'd1);
        cycle("ovf", 1, 8'hEE, 0);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle("drain", 0, 8'h00, 1);
`ifndef FIFO_FWFT_EN
            chk("drain.order", 32'(data_out), 32'(i));
            chk("drain.rv", 32'(rd_valid), 32'd1);
`endif
        end
        chk("drain.empty", 32'(empty), 32'd1);
        cycle("idle", 0, 8'h00, 0);

        // Underflow, then flush clears the flags
        cycle("udf", 0, 8'h00, 1);
        chk("udf.flag", 32'(underflow), 32'd1);
        chk("udf.count", 32'(count), 32'd0);
        cycle("clr", 0, 8'h00, 0, 1);
        chk("clr.udf0", 32'(underflow), 32'd0);
        chk("clr.ovf0", 32'(overflow), 32'd0);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) cycle("fill2", 1, 8'(8'h10 + i), 0);
        cycle("full_rw", 1, 8'hA5, 1);
        chk("full_rw.count", 32'(count), 32'd16);
        chk("full_rw.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle("drain2", 0, 8'h00, 1);
`ifndef FIFO_FWFT_EN
        chk("drain2.last_a5", 32'(data_out), 32'hA5);
`endif
        cycle("empty_rw", 1, 8'h77, 1);
        chk("empty_rw.count1", 32'(count), 32'd1);
        chk("empty_rw.unf", 32'(underflow), 32'd1);
        cycle("clr2", 0, 8'h00, 0, 1);

        // Randomised phases bias toward full, toward empty, then balanced
        for (int i = 0; i < 1200; i++) begin
            int pw, pr;
            if (i < 300)      begin pw = 90; pr = 50; end
            else if (i < 600) begin pw = 50; pr = 90; end
            else              begin pw = 90; pr = 85; end
            cycle("rand", $urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                  $urandom_range(999) == 0);
        end
        cycle("clr3", 0, 8'h00, 0, 1);

`ifdef FIFO_FWFT_EN
        cycle("fwft_wr", 1, 8'h3C, 0);
        chk("fwft.dout", 32'(data_out), 32'h3C);
        chk("fwft.rv", 32'(rd_valid), 32'd1);
        cycle("fwft_hold", 0, 8'h00, 0);
        chk("fwft.hold", 32'(data_out), 32'h3C);
        cycle("fwft_pop", 0, 8'h00, 1);
        chk("fwft.empty", 32'(empty), 32'd1);
        chk("fwft.rv0", 32'(rd_valid), 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
